// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths, stereo pair type and FSM state types for the I2S-to-SPI return path
package audio_pkg;

  localparam int SAMPLE_BITS   = 16;
  localparam int SPI_WORD_BITS = 32;

  // Left channel occupies the MSBs of the SPI word.
  typedef struct packed {
    logic [SAMPLE_BITS-1:0] left;
    logic [SAMPLE_BITS-1:0] right;
  } stereo_pair_t;

  typedef enum logic [1:0] {
    CAP_IDLE_SYNC,
    CAP_SHIFT,
    CAP_HOLD
  } cap_state_e;

  typedef enum logic {
    TX_DESEL,
    TX_SHIFT
  } tx_state_e;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - first-word-fall-through FIFO holding completed stereo pairs
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wdata     : write request and data; dropped when full unless popping in the same cycle
//   pop, rdata      : read request; rdata always shows the head entry
//   full, empty     : occupancy flags
//   level           : number of stored entries
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = SPI_WORD_BITS,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == (PTR_W+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push & (~full | pop);
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level_d  = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + (PTR_W+1)'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/i2s_capture_spi_transmitter.sv
// rtl/i2s_capture_spi_transmitter.sv - captures I2S stereo samples and streams buffered pairs out on SPI MISO
// Ports:
//   serial_clk        : single clock, all logic on posedge
//   reset             : asynchronous active-low reset
//   i2s_ws_in         : word select, 0 = left, 1 = right
//   i2s_sound_bit_in  : I2S serial data
//   spi_chip_select   : active-low host select
//   spi_miso          : pair data to host, MSB first
//   rx_bit_number     : current capture bit counter
//   fifo_level        : stored pairs
//   overflow          : pulse when a completed pair is dropped
//   underrun          : pulse when a word is loaded from an empty FIFO
//   frame_err         : pulse when a slot ends before all sample bits arrived
module i2s_capture_spi_transmitter #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          serial_clk,
  input  logic                          reset,
  input  logic                          i2s_ws_in,
  input  logic                          i2s_sound_bit_in,
  input  logic                          spi_chip_select,
  output logic                          spi_miso,
  output logic [$clog2(SLOT_BITS):0]    rx_bit_number,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun,
  output logic                          frame_err
);

  import audio_pkg::*;

  localparam int CNT_W = $clog2(SLOT_BITS) + 1;
  localparam int TXC_W = $clog2(SPI_WORD_BITS);

  cap_state_e               cap_state_q, cap_state_d;
  logic                     ws_prev_q, ws_prev_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-1:0]   shreg_q, shreg_d;
  logic [SAMPLE_BITS-1:0]   left_q, left_d;
  logic                     left_valid_q, left_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     push;
  stereo_pair_t             push_pair;

  tx_state_e                tx_state_q, tx_state_d;
  logic                     cs_prev_q, cs_prev_d;
  logic [SPI_WORD_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [TXC_W-1:0]         tx_cnt_q, tx_cnt_d;
  logic                     miso_q, miso_d;
  logic                     underrun_q, underrun_d;
  logic                     overflow_q, overflow_d;
  logic                     load, pop;

  logic [SPI_WORD_BITS-1:0] fifo_rdata;
  logic                     fifo_full, fifo_empty;

  // The right sample is taken from shreg_d so the pair is pushed on the edge its LSB arrives.
  assign push_pair = {left_q, shreg_d};

  sample_fifo #(
    .WIDTH (SPI_WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (serial_clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_pair),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    cap_state_d  = cap_state_q;
    ws_prev_d    = i2s_ws_in;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    left_d       = left_q;
    left_valid_d = left_valid_q;
    frame_err_d  = 1'b0;
    push         = 1'b0;
    if (i2s_ws_in != ws_prev_q) begin
      // SD on the WS edge cycle is the previous slot's LSB, so it is not captured.
      if (cap_state_q == CAP_SHIFT && bit_cnt_q != '0) begin
        frame_err_d  = 1'b1;
        left_valid_d = 1'b0;
      end
      bit_cnt_d   = '0;
      shreg_d     = '0;
      cap_state_d = CAP_SHIFT;
    end else if (cap_state_q == CAP_SHIFT) begin
      shreg_d   = {shreg_q[SAMPLE_BITS-2:0], i2s_sound_bit_in};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (bit_cnt_q == CNT_W'(SAMPLE_BITS - 1)) begin
        cap_state_d = CAP_HOLD;
        if (!ws_prev_q) begin
          left_d       = shreg_d;
          left_valid_d = 1'b1;
        end else if (left_valid_q) begin
          push         = 1'b1;
          left_valid_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    cs_prev_d  = spi_chip_select;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    load       = 1'b0;
    if (spi_chip_select) begin
      tx_state_d = TX_DESEL;
      tx_cnt_d   = '0;
    end else if (cs_prev_q || tx_cnt_q == TXC_W'(SPI_WORD_BITS - 1)) begin
      // Reloading in place of the 32nd shift keeps consecutive words gapless.
      load = 1'b1;
    end else if (tx_state_q == TX_SHIFT) begin
      tx_shift_d = {tx_shift_q[SPI_WORD_BITS-2:0], 1'b0};
      tx_cnt_d   = tx_cnt_q + TXC_W'(1);
    end
    pop        = load;
    underrun_d = load & fifo_empty;
    if (load) begin
      tx_shift_d = fifo_empty ? '0 : fifo_rdata;
      tx_cnt_d   = '0;
      tx_state_d = TX_SHIFT;
    end
    miso_d     = ~spi_chip_select & tx_shift_d[SPI_WORD_BITS-1];
    overflow_d = push & fifo_full & ~pop;
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      cap_state_q  <= CAP_IDLE_SYNC;
      ws_prev_q    <= 1'b0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      left_q       <= '0;
      left_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      tx_state_q   <= TX_DESEL;
      cs_prev_q    <= 1'b1;
      tx_shift_q   <= '0;
      tx_cnt_q     <= '0;
      miso_q       <= 1'b0;
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cap_state_q  <= cap_state_d;
      ws_prev_q    <= ws_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      left_q       <= left_d;
      left_valid_q <= left_valid_d;
      frame_err_q  <= frame_err_d;
      tx_state_q   <= tx_state_d;
      cs_prev_q    <= cs_prev_d;
      tx_shift_q   <= tx_shift_d;
      tx_cnt_q     <= tx_cnt_d;
      miso_q       <= miso_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
    end
  end

  assign spi_miso      = miso_q;
  assign rx_bit_number = bit_cnt_q;
  assign overflow      = overflow_q;
  assign underrun      = underrun_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_i2s_capture_spi_transmitter.sv
// tb/tb_i2s_capture_spi_transmitter.sv - directed self-checking bench for i2s_capture_spi_transmitter
module tb_i2s_capture_spi_transmitter;

  logic       serial_clk = 1'b0;
  logic       reset;
  logic       i2s_ws_in;
  logic       i2s_sound_bit_in;
  logic       spi_chip_select;
  logic       spi_miso;
  logic [5:0] rx_bit_number;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       underrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int ovf_pulses = 0;
  int ferr_pulses = 0;
  logic [31:0] rd_words [4];
  int ur_seen;
  int ur_first;

  i2s_capture_spi_transmitter dut (
    .serial_clk       (serial_clk),
    .reset            (reset),
    .i2s_ws_in        (i2s_ws_in),
    .i2s_sound_bit_in (i2s_sound_bit_in),
    .spi_chip_select  (spi_chip_select),
    .spi_miso         (spi_miso),
    .rx_bit_number    (rx_bit_number),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .underrun         (underrun),
    .frame_err        (frame_err)
  );

  always #5 serial_clk = ~serial_clk;

  always @(negedge serial_clk) begin
    if (overflow === 1'b1) ovf_pulses++;
    if (frame_err === 1'b1) ferr_pulses++;
  end

  task automatic do_reset();
    reset = 1'b0;
    spi_chip_select = 1'b1;
    i2s_ws_in = 1'b0;
    i2s_sound_bit_in = 1'b0;
    repeat (2) @(negedge serial_clk);
    reset = 1'b1;
  endtask

  // Slot cycle 0 carries the WS change; cycles 1..16 carry the sample MSB first.
  task automatic drive_slot(input logic ws, input logic [15:0] data, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge serial_clk);
      i2s_ws_in = ws;
      i2s_sound_bit_in = (i >= 1 && i <= 16) ? data[16-i] : 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    drive_slot(1'b0, l, 32);
    drive_slot(1'b1, r, 32);
  endtask

  task automatic spi_read(input int n);
    for (int w = 0; w < 4; w++) rd_words[w] = '0;
    ur_seen = 0;
    ur_first = -1;
    @(negedge serial_clk);
    spi_chip_select = 1'b0;
    for (int k = 0; k < 32 * n; k++) begin
      @(negedge serial_clk);
      rd_words[k/32][31-(k%32)] = spi_miso;
      if (underrun === 1'b1) begin
        ur_seen++;
        if (ur_first < 0) ur_first = k;
      end
      if (k == 32 * n - 1) spi_chip_select = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge serial_clk);
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %0b expected 0", spi_miso); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %0b expected 0", underrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
    checks++; if (rx_bit_number !== 6'd0) begin errors++; $display("FAIL reset_rx_bit: got %0d expected 0", rx_bit_number); end
  endtask

  task automatic test_startup();
    do_reset();
    drive_slot(1'b1, 16'hBEEF, 32);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL startup_level: got %0d expected 0", fifo_level); end
    checks++; if (rx_bit_number !== 6'd16) begin errors++; $display("FAIL startup_rx_bit: got %0d expected 16", rx_bit_number); end
    send_frame(16'h1111, 16'h2222);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL startup_level_after_pair: got %0d expected 1", fifo_level); end
    spi_read(1);
    checks++; if (rd_words[0] !== 32'h11112222) begin errors++; $display("FAIL startup_word: got %h expected 11112222", rd_words[0]); end
  endtask

  task automatic test_normal_frame();
    do_reset();
    drive_slot(1'b1, 16'h0000, 32);
    send_frame(16'hA5A5, 16'h1234);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL normal_level: got %0d expected 1", fifo_level); end
    spi_read(1);
    checks++; if (rd_words[0] !== 32'hA5A51234) begin errors++; $display("FAIL normal_word: got %h expected a5a51234", rd_words[0]); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL normal_level_after: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_words [4];
    int o0;
    exp_words = '{32'h00010001, 32'h00020002, 32'h00030003, 32'h00040004};
    do_reset();
    drive_slot(1'b1, 16'h0000, 32);
    o0 = ovf_pulses;
    for (int f = 1; f <= 5; f++) send_frame(16'(f), 16'(f));
    checks++; if (ovf_pulses - o0 !== 1) begin errors++; $display("FAIL overflow_pulses: got %0d expected 1", ovf_pulses - o0); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL overflow_level: got %0d expected 4", fifo_level); end
    spi_read(4);
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (rd_words[w] !== exp_words[w]) begin
        errors++; $display("FAIL overflow_word%0d: got %h expected %h", w, rd_words[w], exp_words[w]);
      end
    end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL overflow_level_after: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_underrun_streaming();
    do_reset();
    drive_slot(1'b1, 16'h0000, 32);
    send_frame(16'hFFFF, 16'h0000);
    spi_read(2);
    checks++; if (rd_words[0] !== 32'hFFFF0000) begin errors++; $display("FAIL stream_word0: got %h expected ffff0000", rd_words[0]); end
    checks++; if (rd_words[1] !== 32'h00000000) begin errors++; $display("FAIL stream_word1: got %h expected 00000000", rd_words[1]); end
    checks++; if (ur_seen !== 1) begin errors++; $display("FAIL underrun_count: got %0d expected 1", ur_seen); end
    checks++; if (ur_first !== 32) begin errors++; $display("FAIL underrun_cycle: got %0d expected 32", ur_first); end
  endtask

  task automatic test_short_slot();
    int f0;
    do_reset();
    drive_slot(1'b1, 16'h0000, 32);
    f0 = ferr_pulses;
    drive_slot(1'b0, 16'hABCD, 9);
    drive_slot(1'b1, 16'h5555, 32);
    checks++; if (ferr_pulses - f0 !== 1) begin errors++; $display("FAIL short_frame_err: got %0d expected 1", ferr_pulses - f0); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL short_level: got %0d expected 0", fifo_level); end
    send_frame(16'h0F0F, 16'hF0F0);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL short_recover_level: got %0d expected 1", fifo_level); end
  endtask

  task automatic test_reset_mid_operation();
    do_reset();
    drive_slot(1'b1, 16'h0000, 32);
    send_frame(16'h0001, 16'h0002);
    send_frame(16'h0003, 16'h0004);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL midrst_level_before: got %0d expected 2", fifo_level); end
    @(negedge serial_clk);
    spi_chip_select = 1'b0;
    repeat (10) @(negedge serial_clk);
    reset = 1'b0;
    #1;
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %0b expected 0", spi_miso); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d expected 0", fifo_level); end
    checks++; if ({overflow, underrun, frame_err} !== 3'b000) begin errors++; $display("FAIL midrst_pulses: got %b expected 000", {overflow, underrun, frame_err}); end
    @(negedge serial_clk);
    spi_chip_select = 1'b1;
    reset = 1'b1;
    @(negedge serial_clk);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL midrst_level_after: got %0d expected 0", fifo_level); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL midrst_miso_after: got %0b expected 0", spi_miso); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun_after: got %0b expected 0", underrun); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_normal_frame();
    test_overflow();
    test_underrun_streaming();
    test_short_slot();
    test_reset_mid_operation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
